// File: rtl/sgmii_rate_adapter.sv
// Rate adapter between a byte-per-MAC-strobe GMII and the fixed 125 MHz PCS GMII.
// TX bytes are replicated R times and RX replicas are decimated back to one byte per strobe.
module sgmii_rate_adapter #(
  parameter int REP_100M = 10,
  parameter int REP_10M  = 100,
  parameter int CNT_W    = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEL_SGMII,
  input  logic [1:0] SGMII_LINK,
  input  logic [7:0] MAC_TXD,
  input  logic       MAC_TX_EN,
  input  logic       MAC_TX_ER,
  output logic       MAC_TX_CE,
  output logic [7:0] MAC_RXD,
  output logic       MAC_RX_DV,
  output logic       MAC_RX_ER,
  output logic       MAC_RX_CE,
  output logic [7:0] PCS_TXD,
  output logic       PCS_TX_EN,
  output logic       PCS_TX_ER,
  input  logic [7:0] PCS_RXD,
  input  logic       PCS_RX_DV,
  input  logic       PCS_RX_ER,
  output logic [1:0] SPEED,
  output logic       SPEED_PEND
);

  localparam logic [1:0] SPD_10M  = 2'b00;
  localparam logic [1:0] SPD_100M = 2'b01;
  localparam logic [1:0] SPD_1G   = 2'b10;

  localparam logic [CNT_W-1:0] MAX_10M  = CNT_W'(REP_10M - 1);
  localparam logic [CNT_W-1:0] MAX_100M = CNT_W'(REP_100M - 1);

  logic [1:0]       req;
  logic [CNT_W-1:0] rep_max;
  logic [CNT_W-1:0] rx_restart;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;
  logic             idle;
  logic             apply;
  logic             pcs_dv_q;
  logic             dv_rise;
  logic             dv_fall;
  logic             rx_sample;
  logic             er_acc;

  // Link code 11 is reserved and treated as gigabit.
  always_comb begin
    req = SPD_1G;
    if (SEL_SGMII && (SGMII_LINK != 2'b11)) begin
      req = SGMII_LINK;
    end
  end

  always_comb begin
    rep_max = '0;
    case (SPEED)
      SPD_10M:  rep_max = MAX_10M;
      SPD_100M: rep_max = MAX_100M;
      default:  rep_max = '0;
    endcase
  end

  assign rx_restart = (rep_max == '0) ? '0 : CNT_W'(1);

  assign idle       = !PCS_TX_EN && !MAC_TX_EN && !PCS_RX_DV && !MAC_RX_DV;
  assign apply      = idle && (req != SPEED);
  assign SPEED_PEND = (req != SPEED);
  assign MAC_TX_CE  = (tx_cnt == '0);

  assign dv_rise   = PCS_RX_DV && !pcs_dv_q;
  assign dv_fall   = !PCS_RX_DV && pcs_dv_q;
  assign rx_sample = (rx_cnt == '0) || dv_rise || dv_fall;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SPEED <= SPD_1G;
    end else if (apply) begin
      SPEED <= req;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_cnt    <= '0;
      PCS_TXD   <= '0;
      PCS_TX_EN <= 1'b0;
      PCS_TX_ER <= 1'b0;
    end else begin
      if (apply || (tx_cnt == rep_max)) begin
        tx_cnt <= '0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (MAC_TX_CE) begin
        PCS_TXD   <= MAC_TXD;
        PCS_TX_EN <= MAC_TX_EN;
        PCS_TX_ER <= MAC_TX_ER;
      end
    end
  end

  // DV edges treat the current cycle as window slot 0 so sampling follows the frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_cnt    <= '0;
      pcs_dv_q  <= 1'b0;
      er_acc    <= 1'b0;
      MAC_RXD   <= '0;
      MAC_RX_DV <= 1'b0;
      MAC_RX_ER <= 1'b0;
      MAC_RX_CE <= 1'b0;
    end else begin
      pcs_dv_q  <= PCS_RX_DV;
      MAC_RX_CE <= rx_sample;
      if (apply) begin
        rx_cnt <= '0;
      end else if (dv_rise || dv_fall) begin
        rx_cnt <= rx_restart;
      end else if (rx_cnt == rep_max) begin
        rx_cnt <= '0;
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
      if (rx_sample) begin
        MAC_RXD   <= PCS_RXD;
        MAC_RX_DV <= PCS_RX_DV;
        MAC_RX_ER <= PCS_RX_ER || er_acc;
        er_acc    <= 1'b0;
      end else if (PCS_RX_ER) begin
        er_acc <= 1'b1;
      end
    end
  end

endmodule
